int_ctrl: RTL and testbench
===========================

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 4: number of maskable request lines (range 1..16).
REQ-002 Parameter ID_W, default $clog2(NUM_IRQ) with a minimum of 1: width of int_id.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 nmi  in  1  non-maskable request, rising-edge sensitive.
REQ-006 irq  in  NUM_IRQ  maskable requests, level sensitive.
REQ-007 mask_we  in  1  loads mask register from mask_in.
REQ-008 mask_in  in  NUM_IRQ  mask value; 1 = source enabled.
REQ-009 ctl_im_we  in  1  loads interrupt mode from db.
REQ-010 db  in  2  mode code: 0x/01 = IM0, 10 = IM1, 11 = IM2.
REQ-011 ctl_iffx_we  in  1  IFF write strobe.
REQ-012 ctl_iffx_bit  in  1  IFF write value: 1 = EI, 0 = DI.
REQ-013 ctl_iff1_iff2  in  1  RETN copy, iff1 <= iff2.
REQ-014 setM1  in  1  instruction-boundary strobe; the only cycle on which requests are accepted.
REQ-015 ctl_no_ints  in  1  suppresses acceptance on the current setM1.
REQ-016 ack_done  in  1  core finished the acknowledge sequence.
REQ-017 iff1, iff2, im1, im2  out  1 each  registered state.
REQ-018 in_nmi, in_intr  out  1 each  high while in NMI or INT acknowledge.
REQ-019 int_id  out  ID_W  index of the accepted maskable source; held until the next acceptance.
REQ-020 int_pending  out  1  combinational OR of (irq & mask).

Function
REQ-021 NMI edge detector: nmi_q samples nmi each cycle; nmi high with nmi_q low sets nmi_latch.
REQ-022 nmi_latch clears only on NMI acceptance; an edge arriving during the acceptance cycle is latched again.
REQ-023 FSM states IDLE, NMI_ACK, INT_ACK; acceptance is evaluated only in IDLE with setM1=1 and ctl_no_ints=0.
REQ-024 IDLE->NMI_ACK when nmi_latch=1: iff1<=0, iff2 unchanged, nmi_latch<=0; NMI has priority over irq.
REQ-025 IDLE->INT_ACK when the NMI condition is false and the following all hold: (irq & mask)!=0, iff1=1, ei_block=0.
REQ-026 On IDLE->INT_ACK: iff1<=0, iff2<=0, int_id <= lowest set index of (irq & mask).
REQ-027 in_nmi and in_intr are registered and asserted from the cycle after acceptance.
REQ-028 NMI_ACK/INT_ACK->IDLE on ack_done=1; in_nmi/in_intr deassert the following cycle.
REQ-029 setM1 in a non-IDLE state is ignored.
REQ-030 EI (ctl_iffx_we=1, ctl_iffx_bit=1): iff1<=1, iff2<=1, ei_block<=1.
REQ-031 ei_block clears on the first setM1 after EI; no maskable acceptance occurs on that setM1.
REQ-032 DI (ctl_iffx_we=1, ctl_iffx_bit=0): iff1<=0, iff2<=0, ei_block<=0.
REQ-033 ctl_iff1_iff2=1 with ctl_iffx_we=0: iff1<=iff2.
REQ-034 ctl_iffx_we takes precedence over ctl_iff1_iff2 when both are asserted.
REQ-035 Acceptance-driven IFF clearing overrides any IFF write in the same cycle.
REQ-036 Acceptance decisions use register values from before that cycle's writes.
REQ-037 Mode decode: im1 = (mode==10), im2 = (mode==11); a mode write takes effect the next cycle.
REQ-038 A mask write takes effect for acceptance the next cycle; int_pending reflects the new mask once it is registered.
REQ-039 An irq deasserted before setM1 is never accepted (no maskable latching).

Reset
REQ-040 With reset=1 at a clock edge: iff1=iff2=0, mode=IM0 (im1=im2=0), mask=all ones, nmi_latch=0, nmi_q=0, ei_block=0, state=IDLE, in_nmi=in_intr=0, int_id=0.
REQ-041 Reset mid-acknowledge returns to IDLE the next cycle without requiring ack_done.
REQ-042 An nmi held high through reset release does not create an edge; nmi_q is loaded from nmi during reset.

Structure
REQ-043 Package int_ctrl_pkg holds the FSM state enum and the IM mode code constants (IM0, IM1, IM2).
REQ-044 Sub-module int_prio_enc, parametrised by NUM_IRQ, provides the lowest-index-first encoder that outputs index and valid.

Verification
REQ-045 Reset, then db=10 with ctl_im_we -> im1=1/im2=0; db=11 -> im1=0/im2=1; db=00 -> im1=0/im2=0.
REQ-046 EI, irq=4'b0100, setM1 on the next cycle -> no acceptance (ei_block); second setM1 -> in_intr=1, int_id=2, iff1=iff2=0.
REQ-047 iff1=iff2=1, nmi pulse and irq=4'b0001, then setM1 -> in_nmi=1, iff1=0, iff2=1; ack_done, then ctl_iff1_iff2 -> iff1=1.
REQ-048 irq=4'b1010, mask_in=4'b1000 written, EI, two setM1 -> int_id=3.
REQ-049 nmi held high across reset release, then setM1 -> no in_nmi; nmi low then high, then setM1 -> in_nmi=1.
REQ-050 Reset asserted while in_intr=1 -> next cycle in_intr=0, state IDLE, iff1=0.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// ============================================================================
//  Module   : int_ctrl_pkg
//  Purpose  : Shared FSM state type and interrupt-mode codes for int_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package int_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        NMI_ACK = 2'd1,
        INT_ACK = 2'd2
    } state_e;

    localparam logic [1:0] c_IM0 = 2'b00;
    localparam logic [1:0] c_IM1 = 2'b10;
    localparam logic [1:0] c_IM2 = 2'b11;

endpackage

`default_nettype wire

// File: rtl/int_prio_enc.sv
// ============================================================================
//  Module   : int_prio_enc
//  Purpose  : Lowest-index-first priority encoder with valid flag.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_prio_enc #(
    parameter int NUM_IRQ = 4,
    parameter int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic [ID_W-1:0]    idx,
    output logic               valid
);

    // Scanning downward lets the lowest set bit win the last assignment.
    always_comb begin
        idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) idx = ID_W'(i);
        end
    end

    assign valid = |req;

endmodule

`default_nettype wire

// File: rtl/int_ctrl.sv
// ============================================================================
//  Module   : int_ctrl
//  Purpose  : Interrupt controller with edge NMI, masked level IRQs, IFFs/IM.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 4,
    parameter int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               nmi,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_in,
    input  logic               ctl_im_we,
    input  logic [1:0]         db,
    input  logic               ctl_iffx_we,
    input  logic               ctl_iffx_bit,
    input  logic               ctl_iff1_iff2,
    input  logic               setM1,
    input  logic               ctl_no_ints,
    input  logic               ack_done,
    output logic               iff1,
    output logic               iff2,
    output logic               im1,
    output logic               im2,
    output logic               in_nmi,
    output logic               in_intr,
    output logic [ID_W-1:0]    int_id,
    output logic               int_pending
);

    state_e               r_state;
    state_e               w_state_nxt;
    logic                 r_iff1;
    logic                 r_iff2;
    logic                 r_ei_block;
    logic [1:0]           r_mode;
    logic [NUM_IRQ-1:0]   r_mask;
    logic                 r_nmi_q;
    logic                 r_nmi_latch;
    logic                 r_in_nmi;
    logic                 r_in_intr;
    logic [ID_W-1:0]      r_int_id;

    logic [NUM_IRQ-1:0]   w_masked;
    logic [ID_W-1:0]      w_enc_idx;
    logic                 w_enc_valid;
    logic                 w_boundary;
    logic                 w_take_nmi;
    logic                 w_take_int;

    assign w_masked = irq & r_mask;

    int_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .req   (w_masked),
        .idx   (w_enc_idx),
        .valid (w_enc_valid)
    );

    // All acceptance terms use pre-edge register values.
    assign w_boundary = (r_state == IDLE) && setM1 && !ctl_no_ints;
    assign w_take_nmi = w_boundary && r_nmi_latch;
    assign w_take_int = w_boundary && !r_nmi_latch && w_enc_valid && r_iff1 && !r_ei_block;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_take_nmi)      w_state_nxt = NMI_ACK;
                else if (w_take_int) w_state_nxt = INT_ACK;
            end
            NMI_ACK, INT_ACK: begin
                if (ack_done) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_iff1      <= 1'b0;
            r_iff2      <= 1'b0;
            r_ei_block  <= 1'b0;
            r_mode      <= c_IM0;
            r_mask      <= '1;
            r_nmi_q     <= nmi;
            r_nmi_latch <= 1'b0;
            r_in_nmi    <= 1'b0;
            r_in_intr   <= 1'b0;
            r_int_id    <= '0;
        end else begin
            r_nmi_q   <= nmi;
            r_in_nmi  <= (w_state_nxt == NMI_ACK);
            r_in_intr <= (w_state_nxt == INT_ACK);

            // A fresh edge in the acceptance cycle must survive the clear.
            if (nmi && !r_nmi_q) r_nmi_latch <= 1'b1;
            else if (w_take_nmi) r_nmi_latch <= 1'b0;

            if (w_take_nmi) begin
                r_iff1 <= 1'b0;
            end else if (w_take_int) begin
                r_iff1 <= 1'b0;
                r_iff2 <= 1'b0;
            end else if (ctl_iffx_we) begin
                r_iff1 <= ctl_iffx_bit;
                r_iff2 <= ctl_iffx_bit;
            end else if (ctl_iff1_iff2) begin
                r_iff1 <= r_iff2;
            end

            if (ctl_iffx_we) r_ei_block <= ctl_iffx_bit;
            else if (setM1)  r_ei_block <= 1'b0;

            if (w_take_int) r_int_id <= w_enc_idx;

            if (mask_we) r_mask <= mask_in;

            if (ctl_im_we) begin
                case (db)
                    c_IM1:   r_mode <= c_IM1;
                    c_IM2:   r_mode <= c_IM2;
                    default: r_mode <= c_IM0;
                endcase
            end
        end
    end

    assign iff1        = r_iff1;
    assign iff2        = r_iff2;
    assign im1         = (r_mode == c_IM1);
    assign im2         = (r_mode == c_IM2);
    assign in_nmi      = r_in_nmi;
    assign in_intr     = r_in_intr;
    assign int_id      = r_int_id;
    assign int_pending = |w_masked;

endmodule

`default_nettype wire

// File: tb/tb_int_ctrl.sv
// ============================================================================
//  Module   : tb_int_ctrl
//  Purpose  : Directed self-checking bench for int_ctrl with a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_int_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       nmi;
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_in;
    logic       ctl_im_we;
    logic [1:0] db;
    logic       ctl_iffx_we;
    logic       ctl_iffx_bit;
    logic       ctl_iff1_iff2;
    logic       setM1;
    logic       ctl_no_ints;
    logic       ack_done;
    logic       iff1, iff2, im1, im2, in_nmi, in_intr, int_pending;
    logic [1:0] int_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    int_ctrl #(.NUM_IRQ(4)) dut (
        .clk(clk), .reset(reset), .nmi(nmi), .irq(irq),
        .mask_we(mask_we), .mask_in(mask_in),
        .ctl_im_we(ctl_im_we), .db(db),
        .ctl_iffx_we(ctl_iffx_we), .ctl_iffx_bit(ctl_iffx_bit),
        .ctl_iff1_iff2(ctl_iff1_iff2), .setM1(setM1),
        .ctl_no_ints(ctl_no_ints), .ack_done(ack_done),
        .iff1(iff1), .iff2(iff2), .im1(im1), .im2(im2),
        .in_nmi(in_nmi), .in_intr(in_intr),
        .int_id(int_id), .int_pending(int_pending)
    );

    // Reference model: phase 0 = idle, 1 = servicing NMI, 2 = servicing IRQ.
    int         m_phase;
    logic       m_iff1, m_iff2, m_hold, m_nmi_prev, m_nmi_pend, m_started;
    logic [1:0] m_mode_raw;
    logic [3:0] m_mask;
    logic [1:0] m_id;
    logic       m_can, m_go_nmi, m_go_int;
    logic [3:0] m_req;

    function automatic logic [1:0] lowest(input logic [3:0] v);
        lowest = 2'd0;
        for (int k = 0; k < 4; k++) if (v[k]) return 2'(k);
    endfunction

    initial m_started = 1'b0;

    always_comb begin
        m_req    = irq & m_mask;
        m_can    = setM1 && !ctl_no_ints && (m_phase == 0);
        m_go_nmi = m_can && m_nmi_pend;
        m_go_int = m_can && !m_nmi_pend && (m_req != 4'd0) && m_iff1 && !m_hold;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_started  <= 1'b1;
            m_phase    <= 0;
            m_iff1     <= 1'b0;
            m_iff2     <= 1'b0;
            m_hold     <= 1'b0;
            m_nmi_prev <= nmi;
            m_nmi_pend <= 1'b0;
            m_mode_raw <= 2'b00;
            m_mask     <= 4'hF;
            m_id       <= 2'd0;
        end else begin
            m_nmi_prev <= nmi;
            m_nmi_pend <= (nmi && !m_nmi_prev) ? 1'b1 : (m_go_nmi ? 1'b0 : m_nmi_pend);
            if (m_go_nmi)                      m_phase <= 1;
            else if (m_go_int)                 m_phase <= 2;
            else if (m_phase != 0 && ack_done) m_phase <= 0;
            if (m_go_nmi) m_iff1 <= 1'b0;
            else if (m_go_int) begin m_iff1 <= 1'b0; m_iff2 <= 1'b0; end
            else if (ctl_iffx_we) begin m_iff1 <= ctl_iffx_bit; m_iff2 <= ctl_iffx_bit; end
            else if (ctl_iff1_iff2) m_iff1 <= m_iff2;
            m_hold <= ctl_iffx_we ? ctl_iffx_bit : (setM1 ? 1'b0 : m_hold);
            if (m_go_int)  m_id <= lowest(m_req);
            if (mask_we)   m_mask <= mask_in;
            if (ctl_im_we) m_mode_raw <= db;
        end
    end

    logic [8:0] got_v, exp_v;
    always @(negedge clk) begin
        if (m_started) begin
            got_v = {iff1, iff2, im1, im2, in_nmi, in_intr, int_id, int_pending};
            exp_v = {m_iff1, m_iff2, (m_mode_raw == 2'b10), (m_mode_raw == 2'b11),
                     (m_phase == 1), (m_phase == 2), m_id, |(irq & m_mask)};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL model_cmp t=%0t got %b exp %b", $time, got_v, exp_v);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic do_ei();
        ctl_iffx_we = 1'b1; ctl_iffx_bit = 1'b1;
        tick();
        ctl_iffx_we = 1'b0; ctl_iffx_bit = 1'b0;
    endtask

    task automatic pulse_m1();
        setM1 = 1'b1;
        tick();
        setM1 = 1'b0;
    endtask

    task automatic do_ack();
        ack_done = 1'b1;
        tick();
        ack_done = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; nmi = 1'b0; irq = 4'd0; mask_we = 1'b0; mask_in = 4'd0;
        ctl_im_we = 1'b0; db = 2'd0; ctl_iffx_we = 1'b0; ctl_iffx_bit = 1'b0;
        ctl_iff1_iff2 = 1'b0; setM1 = 1'b0; ctl_no_ints = 1'b0; ack_done = 1'b0;
        tick(); tick();
        reset = 1'b0;
        expect_v("rst_iff", {2'b0, iff1, iff2}, 4'b0000);
        expect_v("rst_im", {2'b0, im1, im2}, 4'b0000);
        expect_v("rst_in", {2'b0, in_nmi, in_intr}, 4'b0000);
        expect_v("rst_id", {2'b0, int_id}, 4'h0);
        irq = 4'b0001; #1;
        expect_v("rst_mask_pending", {3'b0, int_pending}, 4'h1);
        irq = 4'b0000;

        // Mode decode
        ctl_im_we = 1'b1; db = 2'b10; tick();
        expect_v("im_10", {2'b0, im1, im2}, 4'b0010);
        db = 2'b11; tick();
        expect_v("im_11", {2'b0, im1, im2}, 4'b0001);
        db = 2'b01; tick();
        expect_v("im_01", {2'b0, im1, im2}, 4'b0000);
        db = 2'b00; tick();
        ctl_im_we = 1'b0;
        expect_v("im_00", {2'b0, im1, im2}, 4'b0000);

        // EI blocks the next boundary only
        irq = 4'b0100;
        do_ei();
        expect_v("ei_iff", {2'b0, iff1, iff2}, 4'b0011);
        pulse_m1();
        expect_v("ei_block", {3'b0, in_intr}, 4'h0);
        ctl_no_ints = 1'b1; pulse_m1(); ctl_no_ints = 1'b0;
        expect_v("no_ints", {3'b0, in_intr}, 4'h0);
        pulse_m1();
        expect_v("int_acc", {1'b0, in_intr, iff1, iff2}, 4'b0100);
        expect_v("int_id2", {2'b0, int_id}, 4'h2);
        pulse_m1();
        expect_v("m1_in_ack", {2'b0, in_nmi, in_intr}, 4'b0001);
        do_ack();
        expect_v("int_done", {3'b0, in_intr}, 4'h0);
        irq = 4'b0000;

        // NMI wins over irq, iff2 preserved, RETN restores iff1
        do_ei();
        nmi = 1'b1; tick(); nmi = 1'b0;
        irq = 4'b0001;
        pulse_m1();
        expect_v("nmi_acc", {1'b0, in_nmi, iff1, iff2}, 4'b0101);
        do_ack();
        irq = 4'b0000;
        expect_v("nmi_done", {3'b0, in_nmi}, 4'h0);
        ctl_iff1_iff2 = 1'b1; tick(); ctl_iff1_iff2 = 1'b0;
        expect_v("retn", {2'b0, iff1, iff2}, 4'b0011);

        // Deasserted irq is not remembered
        irq = 4'b0010; tick(); irq = 4'b0000;
        pulse_m1();
        expect_v("no_latch", {3'b0, in_intr}, 4'h0);

        // Mask selects source 3 out of 4'b1010
        irq = 4'b1010;
        mask_we = 1'b1; mask_in = 4'b0001; tick();
        expect_v("mask_off", {3'b0, int_pending}, 4'h0);
        mask_in = 4'b1000; tick(); mask_we = 1'b0;
        expect_v("mask_on", {3'b0, int_pending}, 4'h1);
        do_ei(); pulse_m1(); pulse_m1();
        expect_v("int_id3", {1'b0, in_intr, int_id}, 4'b0111);
        do_ack();
        irq = 4'b0000;

        // NMI held across reset release makes no edge
        nmi = 1'b1; reset = 1'b1; tick(); tick(); reset = 1'b0;
        tick();
        pulse_m1();
        expect_v("nmi_held", {3'b0, in_nmi}, 4'h0);
        nmi = 1'b0; tick(); nmi = 1'b1; tick(); nmi = 1'b0;
        pulse_m1();
        expect_v("nmi_edge", {3'b0, in_nmi}, 4'h1);
        do_ack();

        // Reset in the middle of an IRQ acknowledge
        irq = 4'b0001;
        do_ei(); pulse_m1(); pulse_m1();
        expect_v("pre_rst", {3'b0, in_intr}, 4'h1);
        reset = 1'b1; tick(); reset = 1'b0;
        expect_v("rst_ack", {2'b0, in_intr, iff1}, 4'b0000);
        pulse_m1();
        expect_v("rst_idle", {2'b0, in_nmi, in_intr}, 4'b0000);
        irq = 4'b0000;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
